// File: rtl/default_slave.sv
// -----------------------------------------------------------------------------
// default_slave
//
// Terminating AXI slave for transactions that decode to no mapped slave.
// Every write burst is drained and answered with a single DECERR response.
// Every read burst is answered with LEN+1 beats of zero data marked DECERR.
// The write and read sides are independent and may be busy together.
//
// Handshake rule: a transfer happens on a rising clk edge where both valid
// and ready are high. Once this block raises a valid, the valid and its
// payload stay unchanged until the matching ready is seen.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   DS_AWID/AWADDR/AWLEN/AWValid     write address in   (AWReady out)
//   DS_WData/WStrb/WLast/WValid      write data in      (WReady out), discarded
//   DS_BID/BResp/BValid              write response out (BReady in)
//   DS_ARID/ARADDR/ARLEN/ARValid     read address in    (ARReady out)
//   DS_RID/RData/RResp/RLast/RValid  read data out      (RReady in)
//
// All outputs are decoded from state and capture registers only, so there is
// no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module default_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   DS_AWID,
    input  logic [ADDR_W-1:0] DS_AWADDR,
    input  logic [LEN_W-1:0]  DS_AWLEN,
    input  logic              DS_AWValid,
    output logic              DS_AWReady,

    input  logic [DATA_W-1:0] DS_WData,
    input  logic [STRB_W-1:0] DS_WStrb,
    input  logic              DS_WLast,
    input  logic              DS_WValid,
    output logic              DS_WReady,

    output logic [ID_W-1:0]   DS_BID,
    output logic [1:0]        DS_BResp,
    output logic              DS_BValid,
    input  logic              DS_BReady,

    input  logic [ID_W-1:0]   DS_ARID,
    input  logic [ADDR_W-1:0] DS_ARADDR,
    input  logic [LEN_W-1:0]  DS_ARLEN,
    input  logic              DS_ARValid,
    output logic              DS_ARReady,

    output logic [ID_W-1:0]   DS_RID,
    output logic [DATA_W-1:0] DS_RData,
    output logic [1:0]        DS_RResp,
    output logic              DS_RLast,
    output logic              DS_RValid,
    input  logic              DS_RReady
);

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    w_state_t         w_state, w_next;
    r_state_t         r_state, r_next;
    logic [ID_W-1:0]  bid_q;
    logic [ID_W-1:0]  rid_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;

    logic aw_hs, w_last_hs, ar_hs, r_hs, r_last;

    // Address, burst length on the write side and write payload carry no
    // information for a terminating slave; fold them into one sink net.
    logic unused_inputs;
    assign unused_inputs = ^{DS_AWADDR, DS_AWLEN, DS_WData, DS_WStrb, DS_ARADDR};

    assign aw_hs     = (w_state == W_IDLE) && DS_AWValid;
    assign w_last_hs = (w_state == W_DATA) && DS_WValid && DS_WLast;
    assign ar_hs     = (r_state == R_IDLE) && DS_ARValid;
    assign r_hs      = (r_state == R_DATA) && DS_RReady;
    assign r_last    = (beat_cnt == len_q);

    // ---------------------------------------------------------------- write FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (DS_AWValid) w_next = W_DATA;
            // Burst end is decided by WLast alone; AWLEN is not cross-checked.
            W_DATA:  if (DS_WValid && DS_WLast) w_next = W_RESP;
            W_RESP:  if (DS_BReady) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        DS_AWReady = 1'b0;
        DS_WReady  = 1'b0;
        DS_BValid  = 1'b0;
        DS_BID     = '0;
        DS_BResp   = 2'b00;
        case (w_state)
            W_IDLE: DS_AWReady = 1'b1;
            W_DATA: DS_WReady  = 1'b1;
            W_RESP: begin
                DS_BValid = 1'b1;
                DS_BID    = bid_q;
                DS_BResp  = RESP_DECERR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bid_q <= '0;
        end else if (aw_hs) begin
            bid_q <= DS_AWID;
        end
    end

    // ----------------------------------------------------------------- read FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (DS_ARValid) r_next = R_DATA;
            R_DATA:  if (DS_RReady && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        DS_ARReady = 1'b0;
        DS_RValid  = 1'b0;
        DS_RID     = '0;
        DS_RData   = '0;
        DS_RResp   = 2'b00;
        DS_RLast   = 1'b0;
        case (r_state)
            R_IDLE: DS_ARReady = 1'b1;
            R_DATA: begin
                DS_RValid = 1'b1;
                DS_RID    = rid_q;
                DS_RResp  = RESP_DECERR;
                DS_RLast  = r_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rid_q    <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else if (ar_hs) begin
            rid_q    <= DS_ARID;
            len_q    <= DS_ARLEN;
            beat_cnt <= '0;
        end else if (r_hs && !r_last) begin
            // Holding on the last beat keeps a 16-beat burst from wrapping.
            beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

endmodule
